mem_ic_tile_fill: RTL and testbench
===================================

Name: mem_ic_tile_fill

Overview:
- Memory-side responder that feeds the L1 instruction cache's tile-miss port.
- Accepts 128-bit tile read requests from the cache over the OPM/OK handshake.
- Fetches each tile as two 64-bit beats from the L2/bus side.
- Keeps a one-entry last-tile buffer so an immediately repeated miss (A/B pair straddling one tile, or a refetch after flush-free replay) is answered without bus traffic.

Parameters:
- TIMEOUT, 255: max cycles waiting for busAck on one beat before faulting (8-bit counter).
- ENABLE_TBUF, 1: 1 = last-tile buffer active; 0 = every request goes to the bus.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- memPcAddr  in  32  tile address from L1I$; bits [3:0] ignored.
- memPcOpm  in  5  request opcode from L1I$ (UMEM_OPM_READY / UMEM_OPM_RD_TILE).
- memPcData  out  128  tile data; beat0 in [63:0], beat1 in [127:64].
- memPcOK  out  2  response status to L1I$.
- icFlush  in  1  single-cycle pulse; invalidates the tile buffer.
- busAddr  out  32  beat address.
- busReq  out  1  beat request; held with busAddr until busAck.
- busAck  in  1  beat complete; busData/busErr are valid this cycle.
- busErr  in  1  bus error qualifier on busAck.
- busData  in  64  beat data.

Behaviour:
- Shared encodings:
  - OK: UMEM_OK_READY=2'b00, UMEM_OK_OK=2'b01, UMEM_OK_HOLD=2'b10, UMEM_OK_FAULT=2'b11.
  - OPM: UMEM_OPM_READY=5'h00, UMEM_OPM_RD_TILE=5'h10.
  - Any other OPM value is treated as READY.
- Reset (reset==0, async):
  - state=IDLE, memPcOK=READY, memPcData=0, busReq=0, busAddr=0.
  - Buffer invalid, timeout counter=0.
  - Effective immediately, including mid-fetch; the in-flight beat is abandoned.
- All outputs are registered.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - memPcOK=READY.
  - On RD_TILE, latch reqAddr={memPcAddr[31:4],4'h0}.
  - Buffer hit (ENABLE_TBUF, valid, tag==reqAddr[31:4], no icFlush this cycle): next state DONE with OK and the buffered data. Latency: 1 cycle.
  - Otherwise: next state BEAT0 with busReq=1, busAddr=reqAddr, memPcOK=HOLD.
- BEAT0 / BEAT1:
  - memPcOK=HOLD throughout.
  - On busAck with !busErr, capture busData into the matching half.
  - BEAT0 then moves to BEAT1 with busAddr=reqAddr+8, busReq kept high. There is no idle cycle between beats.
  - BEAT1 then moves to DONE with memPcOK=OK.
  - Miss latency: 1 + ack0 wait + 1 + ack1 wait + 1 cycles; 3 cycles minimum with zero-wait ack.
- Timeout counter:
  - Clears on entry to each beat and increments every cycle without busAck.
  - When it reaches TIMEOUT, or on busAck with busErr: next state DONE, memPcOK=FAULT, memPcData=0, busReq=0.
  - A faulted tile is never written to the buffer.
- Buffer fill:
  - On successful BEAT1 ack, write tag and data and set valid.
  - Exception: if icFlush occurred at any point since the request was latched (sticky flag), the fill is suppressed and the buffer stays invalid.
- DONE:
  - Hold memPcOK (OK/FAULT) and memPcData stable while memPcOpm==RD_TILE.
  - When memPcOpm==READY, move to IDLE and drive memPcOK=READY next cycle.
  - A new RD_TILE is accepted only from IDLE, so at least one READY cycle separates requests.
- Requests are not abortable. If opm drops to READY during BEAT0/BEAT1:
  - The fetch still completes and fills the buffer.
  - DONE then lasts exactly 1 cycle.
- icFlush:
  - In any state, clears valid on the next edge.
  - If it coincides with a fill write, the flush wins.
- busReq is deasserted in IDLE and DONE.
- busAddr holds its last value when busReq is low.

Decomposition:
- UMEM_OK_* and UMEM_OPM_* constants belong in the shared CoreDefs package, together with a state enum localparam set IFT_IDLE/IFT_BEAT0/IFT_BEAT1/IFT_DONE.
- One natural sub-module: ic_tile_buf, the one-entry tag/data/valid register with hit compare and flush-priority write.

Test Plan:
- Zero-wait miss: RD_TILE addr 0x0000_1234, bus acks immediately with 0x1111.., 0x2222.. -> busAddr 0x1230 then 0x1238; memPcOK HOLD for 2 cycles, then OK with data {0x2222..,0x1111..}. Opm READY -> memPcOK READY next cycle.
- Buffer hit: repeat 0x0000_1230 after the previous test -> no busReq; OK one cycle after the request with the same 128-bit data. Same test with ENABLE_TBUF=0 -> full bus fetch.
- Timeout: TIMEOUT=4, busAck never asserted -> HOLD for 4 cycles, then FAULT with data 0, busReq low. Next request to the same address misses.
- Bus error on beat1: busErr with ack1 -> FAULT; buffer not updated, proven by a repeat request issuing busReq.
- Flush mid-fetch: icFlush pulse during BEAT0 -> the tile still returns OK, but the repeated request misses. Flush during IDLE with a valid buffer -> the next same-address request misses.
- Async reset during BEAT1 (reset low between clock edges) -> busReq=0 and memPcOK=READY immediately. After release, the next RD_TILE starts a fresh BEAT0.

Source files
------------

// File: rtl/mem_ic_tile_fill_pkg.sv
// -----------------------------------------------------------------------------
// mem_ic_tile_fill_pkg
// Shared definitions for the L1 I$ tile-miss responder: the UMEM response
// status (OK) and request opcode (OPM) encodings, the fill FSM state enum and
// a small opcode decode helper.
// -----------------------------------------------------------------------------
package mem_ic_tile_fill_pkg;

    // Response status driven back to the cache.
    localparam logic [1:0] UMEM_OK_READY = 2'b00;
    localparam logic [1:0] UMEM_OK_OK    = 2'b01;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
    localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

    // Request opcodes issued by the cache.
    localparam logic [4:0] UMEM_OPM_READY   = 5'h00;
    localparam logic [4:0] UMEM_OPM_RD_TILE = 5'h10;

    typedef enum logic [1:0] {
        IFT_IDLE  = 2'd0,
        IFT_BEAT0 = 2'd1,
        IFT_BEAT1 = 2'd2,
        IFT_DONE  = 2'd3
    } ift_state_e;

    // Only RD_TILE is a request; every other opcode behaves like READY.
    function automatic logic is_rd_tile(input logic [4:0] opm);
        return opm == UMEM_OPM_RD_TILE;
    endfunction

endpackage

// File: rtl/mem_ic_tile_fill_if.sv
// -----------------------------------------------------------------------------
// mem_ic_tile_fill_if
// Bundles the cache-side tile port (memPc*, icFlush) and the L2/bus beat port
// (bus*) of the tile fill responder.
//   slave  : the responder (mem_ic_tile_fill)
//   master : the environment (L1I$ + bus), i.e. whoever drives requests/acks
// -----------------------------------------------------------------------------
interface mem_ic_tile_fill_if;

    logic [31:0]  memPcAddr;   // tile address, bits [3:0] ignored
    logic [4:0]   memPcOpm;    // request opcode
    logic [127:0] memPcData;   // beat1 in [127:64], beat0 in [63:0]
    logic [1:0]   memPcOK;     // response status
    logic         icFlush;     // one-cycle tile buffer invalidate
    logic [31:0]  busAddr;     // beat address
    logic         busReq;      // beat request, held until busAck
    logic         busAck;      // beat complete, busData/busErr valid
    logic         busErr;      // error qualifier on busAck
    logic [63:0]  busData;     // beat data

    modport slave (
        input  memPcAddr, memPcOpm, icFlush, busAck, busErr, busData,
        output memPcData, memPcOK, busAddr, busReq
    );

    modport master (
        output memPcAddr, memPcOpm, icFlush, busAck, busErr, busData,
        input  memPcData, memPcOK, busAddr, busReq
    );

endinterface

// File: rtl/mem_ic_tile_fill_tile_buf.sv
// -----------------------------------------------------------------------------
// ic_tile_buf
// One-entry last-tile buffer: tag, 128-bit data and valid bit.
//   clock, reset : core clock, async active-low reset (clears valid only)
//   flush        : invalidate; wins over a simultaneous write
//   wr_en        : write wr_tag/wr_data and set valid
//   lookup_tag   : tag to compare against the stored entry
//   hit, rd_data : combinational hit and stored data
// With ENABLE=0 the buffer never reports a hit.
// -----------------------------------------------------------------------------
module ic_tile_buf #(
    parameter bit ENABLE = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [27:0]  wr_tag,
    input  logic [127:0] wr_data,
    input  logic [27:0]  lookup_tag,
    output logic         hit,
    output logic [127:0] rd_data
);

    logic         valid_q;
    logic [27:0]  tag_q;
    logic [127:0] data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; valid alone qualifies its contents.
    always_ff @(posedge clock) begin
        if (wr_en && !flush) begin
            tag_q  <= wr_tag;
            data_q <= wr_data;
        end
    end

    assign hit     = ENABLE && valid_q && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/mem_ic_tile_fill.sv
// -----------------------------------------------------------------------------
// mem_ic_tile_fill
// Memory-side responder for the L1 I$ tile-miss port. A RD_TILE request is
// answered either from the one-entry last-tile buffer (1 cycle) or by fetching
// two 64-bit beats from the bus (base, base+8). Every output is registered.
//   clock   : core clock
//   reset   : asynchronous active-low reset
//   mif     : mem_ic_tile_fill_if.slave (memPc* cache port, icFlush, bus* port)
// Parameters:
//   TIMEOUT     : cycles without busAck on one beat before the tile faults
//   ENABLE_TBUF : 1 enables the last-tile buffer, 0 sends every request to bus
// -----------------------------------------------------------------------------
module mem_ic_tile_fill
    import mem_ic_tile_fill_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned ENABLE_TBUF = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_ic_tile_fill_if.slave     mif
);

    ift_state_e   state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         flushed_q, flushed_d;   // icFlush seen since the request
    logic [1:0]   ok_q, ok_d;
    logic [127:0] data_q, data_d;
    logic         bus_req_q, bus_req_d;
    logic [31:0]  bus_addr_q, bus_addr_d;

    logic         fill_en;
    logic         buf_hit;
    logic [127:0] buf_data;
    logic [31:0]  tile_base;
    logic [7:0]   cnt_inc;
    logic         rd_tile;

    assign tile_base = mif.memPcAddr & 32'hFFFF_FFF0;
    assign cnt_inc   = cnt_q + 8'd1;
    assign rd_tile   = is_rd_tile(mif.memPcOpm);

    // Fill data is beat1 (arriving now) over the already captured beat0.
    ic_tile_buf #(.ENABLE(ENABLE_TBUF != 0)) u_tile_buf (
        .clock      (clock),
        .reset      (reset),
        .flush      (mif.icFlush),
        .wr_en      (fill_en),
        .wr_tag     (req_addr_q[31:4]),
        .wr_data    ({mif.busData, data_q[63:0]}),
        .lookup_tag (tile_base[31:4]),
        .hit        (buf_hit),
        .rd_data    (buf_data)
    );

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        ok_d       = ok_q;
        data_d     = data_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        fill_en    = 1'b0;

        case (state_q)
            IFT_IDLE: begin
                ok_d = UMEM_OK_READY;
                if (rd_tile) begin
                    req_addr_d = tile_base;
                    flushed_d  = mif.icFlush;
                    // A flush in the request cycle forces a miss.
                    if (buf_hit && !mif.icFlush) begin
                        state_d = IFT_DONE;
                        ok_d    = UMEM_OK_OK;
                        data_d  = buf_data;
                    end else begin
                        state_d    = IFT_BEAT0;
                        ok_d       = UMEM_OK_HOLD;
                        bus_req_d  = 1'b1;
                        bus_addr_d = tile_base;
                        cnt_d      = 8'd0;
                    end
                end
            end

            IFT_BEAT0, IFT_BEAT1: begin
                ok_d      = UMEM_OK_HOLD;
                flushed_d = flushed_q | mif.icFlush;
                if (mif.busAck && !mif.busErr) begin
                    cnt_d = 8'd0;
                    if (state_q == IFT_BEAT0) begin
                        data_d[63:0] = mif.busData;
                        state_d      = IFT_BEAT1;
                        bus_addr_d   = req_addr_q | 32'h0000_0008;
                    end else begin
                        data_d[127:64] = mif.busData;
                        state_d        = IFT_DONE;
                        ok_d           = UMEM_OK_OK;
                        bus_req_d      = 1'b0;
                        // A flush in this very cycle is handled inside the buffer.
                        fill_en        = !flushed_q;
                    end
                end else if (mif.busAck || (cnt_inc == 8'(TIMEOUT))) begin
                    state_d   = IFT_DONE;
                    ok_d      = UMEM_OK_FAULT;
                    data_d    = '0;
                    bus_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            IFT_DONE: begin
                if (!rd_tile) begin
                    state_d = IFT_IDLE;
                    ok_d    = UMEM_OK_READY;
                end
            end

            default: state_d = IFT_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IFT_IDLE;
            req_addr_q <= '0;
            cnt_q      <= '0;
            flushed_q  <= 1'b0;
            ok_q       <= UMEM_OK_READY;
            data_q     <= '0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            ok_q       <= ok_d;
            data_q     <= data_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
        end
    end

    assign mif.memPcOK   = ok_q;
    assign mif.memPcData = data_q;
    assign mif.busReq    = bus_req_q;
    assign mif.busAddr   = bus_addr_q;

endmodule

// File: tb/tb_mem_ic_tile_fill.sv
// -----------------------------------------------------------------------------
// tb_mem_ic_tile_fill
// Self-checking bench for mem_ic_tile_fill. A driver issues tile requests and
// pushes the expected response (computed from a last-tile model and a
// memory-content function) into a scoreboard; a bus responder serves beats
// with chosen wait/error behaviour; a monitor pops and compares every
// response the DUT presents.
// -----------------------------------------------------------------------------
module tb_mem_ic_tile_fill;
    import mem_ic_tile_fill_pkg::*;

    localparam int TB_TIMEOUT = 8;

    typedef struct {
        bit           hit;
        logic [1:0]   code;
        logic [127:0] data;
        int           hold;
    } exp_t;

    logic clk;
    logic rst_n;
    mem_ic_tile_fill_if mif();

    mem_ic_tile_fill #(.TIMEOUT(TB_TIMEOUT), .ENABLE_TBUF(1)) dut (
        .clock (clk),
        .reset (rst_n),
        .mif   (mif)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         sb[$];
    bit           mon_en   = 1'b0;

    // Reference model of the last-tile buffer and of memory contents.
    bit           m_valid  = 1'b0;
    logic [27:0]  m_tag    = '0;
    logic [127:0] m_data   = '0;
    logic [31:0]  salt     = 32'h0;

    // Bus behaviour for the current transaction.
    logic [31:0]  cur_base = '0;
    int           cur_w0   = 0;
    int           cur_w1   = 0;
    int           cur_err  = 0;   // 0 none, 1 error beat0, 2 error beat1, 3 never ack

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a, a ^ 32'hDEAD_BEEF} ^ {salt, ~salt};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Bus responder: per beat, wait the chosen number of cycles, then ack.
    initial begin
        int beat;
        int wcnt;
        bit new_beat;
        mif.busAck  = 1'b0;
        mif.busErr  = 1'b0;
        mif.busData = '0;
        beat = 0; wcnt = 0; new_beat = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n || !mif.busReq) begin
                mif.busAck = 1'b0;
                mif.busErr = 1'b0;
                beat = 0;
                new_beat = 1'b1;
            end else begin
                if (new_beat) begin
                    new_beat = 1'b0;
                    wcnt = (beat == 0) ? cur_w0 : cur_w1;
                    if (beat == 0) check("bus_addr_beat0", mif.busAddr, cur_base);
                    else           check("bus_addr_beat1", mif.busAddr, cur_base + 32'h8);
                end
                if (cur_err == 3 || wcnt > 0) begin
                    mif.busAck = 1'b0;
                    mif.busErr = 1'b0;
                    if (wcnt > 0) wcnt--;
                end else begin
                    mif.busAck  = 1'b1;
                    mif.busErr  = (cur_err == beat + 1);
                    mif.busData = mem_word(mif.busAddr);
                    beat++;
                    new_beat = 1'b1;
                end
            end
        end
    end

    // Monitor: pop and compare on every new OK/FAULT response.
    initial begin
        logic [1:0]   prev;
        int           hold;
        bit           saw_bus;
        logic [127:0] resp_data;
        exp_t         e;
        prev = UMEM_OK_READY; hold = 0; saw_bus = 1'b0; resp_data = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                prev = UMEM_OK_READY;
                hold = 0;
                saw_bus = 1'b0;
            end else begin
                if (mif.busReq) saw_bus = 1'b1;
                if (mif.memPcOK == UMEM_OK_READY) begin
                    hold = 0;
                    saw_bus = 1'b0;
                end else if (mif.memPcOK == UMEM_OK_HOLD) begin
                    hold++;
                end else begin
                    if (prev != mif.memPcOK) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_resp: got ok=%0d with empty scoreboard", mif.memPcOK);
                        end else begin
                            e = sb.pop_front();
                            check("resp_code", mif.memPcOK, e.code);
                            check("resp_data", mif.memPcData, e.data);
                            check("bus_used", saw_bus, !e.hit);
                            check("hold_cycles", hold, e.hold);
                            resp_data = mif.memPcData;
                        end
                    end else begin
                        check("resp_stable", mif.memPcData, resp_data);
                    end
                    check("busreq_low_done", mif.busReq, 1'b0);
                end
                prev = mif.memPcOK;
            end
        end
    end

    // One complete request: expectation, handshake, release, model update.
    task automatic do_req(input logic [31:0] addr, input int w0, input int w1, input int err,
                          input int flush_at, input int hold_extra, input bit drop,
                          input logic [4:0] rel_opm);
        exp_t        e;
        bit          flushed;
        bit          got;
        int          cyc;
        logic [31:0] base;
        base  = addr & 32'hFFFF_FFF0;
        e.hit = m_valid && (m_tag == base[31:4]) && (flush_at != 0);
        if (e.hit) begin
            e.code = UMEM_OK_OK; e.data = m_data; e.hold = 0;
        end else begin
            case (err)
                0:       begin e.code = UMEM_OK_OK;    e.data = {mem_word(base + 32'h8), mem_word(base)}; e.hold = w0 + w1 + 2; end
                1:       begin e.code = UMEM_OK_FAULT; e.data = '0; e.hold = w0 + 1; end
                2:       begin e.code = UMEM_OK_FAULT; e.data = '0; e.hold = w0 + w1 + 2; end
                default: begin e.code = UMEM_OK_FAULT; e.data = '0; e.hold = TB_TIMEOUT; end
            endcase
        end
        cur_base = base; cur_w0 = w0; cur_w1 = w1; cur_err = err;
        sb.push_back(e);

        @(negedge clk);
        mif.memPcAddr = addr;
        mif.memPcOpm  = UMEM_OPM_RD_TILE;
        mif.icFlush   = (flush_at == 0);
        flushed       = (flush_at == 0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mif.memPcOK == UMEM_OK_OK || mif.memPcOK == UMEM_OK_FAULT) begin
                got = 1'b1;
                mif.icFlush = 1'b0;
            end else begin
                mif.icFlush = (cyc == flush_at);
                if (mif.icFlush) flushed = 1'b1;
                if (drop && cyc == 1) mif.memPcOpm = rel_opm;
            end
        end
        mif.icFlush = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: no response for addr %0h after %0d cycles", addr, cyc);
            mif.memPcOpm = rel_opm;
            repeat (2 * TB_TIMEOUT) @(negedge clk);
        end else begin
            if (!drop) repeat (hold_extra) @(negedge clk);
            mif.memPcOpm = rel_opm;
            @(negedge clk);
            check("ready_after_release", mif.memPcOK, UMEM_OK_READY);
        end

        if (flushed) m_valid = 1'b0;
        else if (!e.hit && err == 0 && got) begin
            m_valid = 1'b1;
            m_tag   = base[31:4];
            m_data  = e.data;
        end
    endtask

    task automatic idle_flush();
        @(negedge clk);
        mif.icFlush = 1'b1;
        @(negedge clk);
        mif.icFlush = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        int n;
        mon_en   = 1'b0;
        cur_base = 32'h0000_7800; cur_w0 = 0; cur_w1 = 5; cur_err = 0;
        @(negedge clk);
        mif.memPcAddr = 32'h0000_7804;
        mif.memPcOpm  = UMEM_OPM_RD_TILE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mif.busReq && mif.busAddr == 32'h0000_7808) && n < 20);
        check("reached_beat1", mif.busAddr, 32'h0000_7808);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busreq", mif.busReq, 1'b0);
        check("rst_ok", mif.memPcOK, UMEM_OK_READY);
        check("rst_data", mif.memPcData, 128'h0);
        mif.memPcOpm = UMEM_OPM_READY;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        mon_en  = 1'b1;
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] last_addr;
        logic [4:0]  rel;
        int          err;
        int          fl;
        rst_n         = 1'b0;
        mif.memPcAddr = '0;
        mif.memPcOpm  = UMEM_OPM_READY;
        mif.icFlush   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ok", mif.memPcOK, UMEM_OK_READY);
        check("reset_data", mif.memPcData, 128'h0);
        check("reset_busreq", mif.busReq, 1'b0);
        check("reset_busaddr", mif.busAddr, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Zero-wait miss, then buffer hit on the same tile.
        do_req(32'h0000_1234, 0, 0, 0, -1, 1, 1'b0, UMEM_OPM_READY);
        do_req(32'h0000_1230, 0, 0, 0, -1, 2, 1'b0, UMEM_OPM_READY);
        // Timeout on a never-acked beat; the same tile misses afterwards.
        do_req(32'h0000_5670, 0, 0, 3, -1, 0, 1'b0, UMEM_OPM_READY);
        do_req(32'h0000_5670, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);
        // Errors on beat1 and on beat0; a repeat must go back to the bus.
        do_req(32'h0000_9990, 1, 2, 2, -1, 0, 1'b0, UMEM_OPM_READY);
        do_req(32'h0000_9998, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);
        do_req(32'h0000_A0A0, 2, 0, 1, -1, 0, 1'b0, UMEM_OPM_READY);
        // Flush mid-fetch: tile returns OK but is not retained.
        do_req(32'h0000_B000, 2, 1, 0, 2, 0, 1'b0, UMEM_OPM_READY);
        do_req(32'h0000_B000, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);
        // Flush while idle with a valid buffer.
        idle_flush();
        do_req(32'h0000_B00C, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);
        // Opcode dropped during the fetch: fetch completes and fills.
        do_req(32'h0000_C000, 1, 1, 0, -1, 0, 1'b1, UMEM_OPM_READY);
        do_req(32'h0000_C004, 0, 0, 0, -1, 0, 1'b0, 5'h07);
        // Flush coinciding with a would-be hit forces a miss.
        do_req(32'h0000_C008, 0, 0, 0, 0, 0, 1'b0, UMEM_OPM_READY);
        // Async reset in BEAT1, then a fresh fetch of a previously buffered tile.
        do_req(32'h0000_7700, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);
        reset_mid_fetch();
        do_req(32'h0000_7700, 0, 0, 0, -1, 0, 1'b0, UMEM_OPM_READY);

        last_addr = 32'h0000_7700;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 4) addr = last_addr ^ 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 1) addr = 32'h0000_1000 + 32'($urandom_range(0, 47));
            else addr = $urandom;
            if ($urandom_range(0, 4) == 0) salt = $urandom;
            err = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            fl  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1;
            rel = ($urandom_range(0, 1) == 1) ? UMEM_OPM_READY : 5'(32'h3 + $urandom_range(0, 8));
            do_req(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), err, fl,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0), rel);
            if ($urandom_range(0, 15) == 0) idle_flush();
            last_addr = addr;
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
